// File: rtl/sa_autosa_sdp_mrdma_pkg.sv
// Shared types and constants for the SDP MRDMA ingress/egress path: precision
// encodings, atom geometry, payload widths and the ingress FSM state encoding.
package sa_autosa_sdp_mrdma_pkg;

    localparam int ATOM_BYTES = 32;
    localparam int DMA_PD_W   = 79;
    localparam int CQ_PD_W    = 14;
    localparam int DIM_W      = 13;
    localparam int ATOM_CNT_W = 14;
    localparam int ADDR_W     = 64;

    typedef enum logic [1:0] {
        PREC_INT8  = 2'd0,
        PREC_INT16 = 2'd1,
        PREC_FP16  = 2'd2
    } prec_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } ig_state_e;

    // Index of the last atom covering a (dimension - 1) value: 32 elements per
    // atom for int8, 16 for the 16-bit formats.
    function automatic logic [DIM_W-1:0] last_atom_idx(input logic [DIM_W-1:0] dim_m1,
                                                       input logic             is_int8);
        return is_int8 ? (dim_m1 >> 5) : (dim_m1 >> 4);
    endfunction

endpackage

// File: rtl/sa_autosa_sdp_mrdma_ig_cnt.sv
// Cube-walk counters for MRDMA ingress: atom/line/surface position, chunk size
// of the current request and end-of-line/surface/layer flags.
module sa_autosa_sdp_mrdma_ig_cnt
    import sa_autosa_sdp_mrdma_pkg::*;
#(
    parameter int MAX_REQ_ATOMS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  fire_i,
    input  logic [1:0]            precision_i,
    input  logic [DIM_W-1:0]      width_i,
    input  logic [DIM_W-1:0]      height_i,
    input  logic [DIM_W-1:0]      channel_i,
    output logic [ATOM_CNT_W-1:0] chunk_atoms_o,
    output logic                  eol_o,
    output logic                  eos_o,
    output logic                  last_o
);

    localparam logic [ATOM_CNT_W-1:0] MAX_CHUNK = ATOM_CNT_W'(MAX_REQ_ATOMS);

    logic                  is_int8;
    logic [ATOM_CNT_W-1:0] apl_q, apl_d;
    logic [ATOM_CNT_W-1:0] atom_cnt_q, atom_cnt_d;
    logic [DIM_W-1:0]      line_last_q, line_last_d;
    logic [DIM_W-1:0]      surf_last_q, surf_last_d;
    logic [DIM_W-1:0]      line_cnt_q, line_cnt_d;
    logic [DIM_W-1:0]      surf_cnt_q, surf_cnt_d;
    logic [ATOM_CNT_W-1:0] remaining;

    assign is_int8       = (precision_i == PREC_INT8);
    assign remaining     = apl_q - atom_cnt_q;
    assign chunk_atoms_o = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
    assign eol_o         = (remaining <= MAX_CHUNK);
    assign eos_o         = eol_o && (line_cnt_q == line_last_q);
    assign last_o        = eos_o && (surf_cnt_q == surf_last_q);

    // NOTE: every always_comb output takes its hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        apl_d       = apl_q;
        atom_cnt_d  = atom_cnt_q;
        line_last_d = line_last_q;
        surf_last_d = surf_last_q;
        line_cnt_d  = line_cnt_q;
        surf_cnt_d  = surf_cnt_q;
        if (load_i) begin
            apl_d       = {1'b0, last_atom_idx(width_i, is_int8)} + ATOM_CNT_W'(1);
            line_last_d = height_i;
            surf_last_d = last_atom_idx(channel_i, is_int8);
            atom_cnt_d  = '0;
            line_cnt_d  = '0;
            surf_cnt_d  = '0;
        end else if (fire_i) begin
            if (eol_o) begin
                atom_cnt_d = '0;
                if (eos_o) begin
                    line_cnt_d = '0;
                    surf_cnt_d = surf_cnt_q + DIM_W'(1);
                end else begin
                    line_cnt_d = line_cnt_q + DIM_W'(1);
                end
            end else begin
                atom_cnt_d = atom_cnt_q + chunk_atoms_o;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apl_q       <= '0;
            atom_cnt_q  <= '0;
            line_last_q <= '0;
            surf_last_q <= '0;
            line_cnt_q  <= '0;
            surf_cnt_q  <= '0;
        end else begin
            apl_q       <= apl_d;
            atom_cnt_q  <= atom_cnt_d;
            line_last_q <= line_last_d;
            surf_last_q <= surf_last_d;
            line_cnt_q  <= line_cnt_d;
            surf_cnt_q  <= surf_cnt_d;
        end
    end

endmodule

// File: rtl/sa_autosa_sdp_mrdma_ig.sv
// SDP MRDMA ingress: walks the source cube and issues paired DMA-read / context
// queue requests. Define SA_AUTOSA_SDP_MRDMA_IG_STALL_CNT_EN for the stall counter.
module sa_autosa_sdp_mrdma_ig
    import sa_autosa_sdp_mrdma_pkg::*;
#(
    parameter int MAX_REQ_ATOMS = 8
) (
    input  logic                autosa_core_clk,
    input  logic                autosa_core_rstn,
    input  logic                op_load,
    input  logic [31:0]         reg2dp_src_base_addr_high,
    input  logic [31:0]         reg2dp_src_base_addr_low,
    input  logic [31:0]         reg2dp_src_line_stride,
    input  logic [31:0]         reg2dp_src_surface_stride,
    input  logic [DIM_W-1:0]    reg2dp_width,
    input  logic [DIM_W-1:0]    reg2dp_height,
    input  logic [DIM_W-1:0]    reg2dp_channel,
    input  logic [1:0]          reg2dp_in_precision,
    output logic [DMA_PD_W-1:0] dma_rd_req_pd,
    output logic                dma_rd_req_vld,
    input  logic                dma_rd_req_rdy,
    output logic [CQ_PD_W-1:0]  ig2cq_pd,
    output logic                ig2cq_pvld,
    input  logic                ig2cq_prdy,
    output logic                ig_done,
    output logic [31:0]         dp2reg_mrdma_ig_stall
);

    localparam logic [31:0]     STRIDE_MASK = ~32'(ATOM_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(ATOM_BYTES - 1);

    ig_state_e             state_q;
    logic [ADDR_W-1:0]     addr_q, line_base_q, surf_base_q;
    logic [31:0]           line_stride_q, surf_stride_q;
    logic                  ig_done_q;

    logic                  pending, fire, load;
    logic                  eol, eos, last;
    logic [ATOM_CNT_W-1:0] chunk_atoms, chunk_m1;
    logic [ADDR_W-1:0]     base_addr_d, line_next_d, surf_next_d, addr_next_d;

    assign pending = (state_q == ST_REQ);
    assign fire    = pending && dma_rd_req_rdy && ig2cq_prdy;
    assign load    = op_load && (state_q == ST_IDLE);

    assign base_addr_d = {reg2dp_src_base_addr_high, reg2dp_src_base_addr_low} & ADDR_MASK;
    assign line_next_d = line_base_q + {32'b0, line_stride_q};
    assign surf_next_d = surf_base_q + {32'b0, surf_stride_q};
    assign addr_next_d = addr_q + {45'b0, chunk_atoms, 5'b0};
    assign chunk_m1    = chunk_atoms - ATOM_CNT_W'(1);

    sa_autosa_sdp_mrdma_ig_cnt #(
        .MAX_REQ_ATOMS(MAX_REQ_ATOMS)
    ) u_cnt (
        .clk          (autosa_core_clk),
        .rst_n        (autosa_core_rstn),
        .load_i       (load),
        .fire_i       (fire),
        .precision_i  (reg2dp_in_precision),
        .width_i      (reg2dp_width),
        .height_i     (reg2dp_height),
        .channel_i    (reg2dp_channel),
        .chunk_atoms_o(chunk_atoms),
        .eol_o        (eol),
        .eos_o        (eos),
        .last_o       (last)
    );

    // Each side's valid waits on the other side's ready so both transfer together.
    assign dma_rd_req_vld = pending && ig2cq_prdy;
    assign ig2cq_pvld     = pending && dma_rd_req_rdy;
    assign dma_rd_req_pd  = pending ? {1'b0, chunk_m1, addr_q} : '0;
    assign ig2cq_pd       = pending ? {last, chunk_m1[DIM_W-1:0]} : '0;
    assign ig_done        = ig_done_q;

    // NOTE: address and stride registers are reset too, so the pd outputs and
    // any bench trace are clean from the first cycle after reset.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            line_base_q   <= '0;
            surf_base_q   <= '0;
            line_stride_q <= '0;
            surf_stride_q <= '0;
            ig_done_q     <= 1'b0;
        end else begin
            ig_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_load) begin
                        state_q       <= ST_REQ;
                        addr_q        <= base_addr_d;
                        line_base_q   <= base_addr_d;
                        surf_base_q   <= base_addr_d;
                        line_stride_q <= reg2dp_src_line_stride & STRIDE_MASK;
                        surf_stride_q <= reg2dp_src_surface_stride & STRIDE_MASK;
                    end
                end
                ST_REQ: begin
                    if (fire) begin
                        if (last) begin
                            state_q   <= ST_DONE;
                            ig_done_q <= 1'b1;
                        end else if (eos) begin
                            surf_base_q <= surf_next_d;
                            line_base_q <= surf_next_d;
                            addr_q      <= surf_next_d;
                        end else if (eol) begin
                            line_base_q <= line_next_d;
                            addr_q      <= line_next_d;
                        end else begin
                            addr_q <= addr_next_d;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SA_AUTOSA_SDP_MRDMA_IG_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            stall_q <= '0;
        end else if (load) begin
            stall_q <= '0;
        end else if (pending && !fire && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign dp2reg_mrdma_ig_stall = stall_q;
`else
    assign dp2reg_mrdma_ig_stall = '0;
`endif

endmodule
